serialparalelo1: RTL and testbench

Serial-to-parallel receiver for the single-lane link driven by the parallel-to-serial transmitter. Samples one bit per clk_32f cycle, finds word alignment on the idle comma 8'hBC, declares the link active after a run of commas, then delivers each non-comma word as an 8-bit byte with a valid flag. It sits at the receiving end of the lane, feeding the downstream byte-wide logic.

---
 rtl/serialparalelo1_pkg.sv | 17 +
 rtl/serialparalelo1_sp_shift_aligner.sv | 39 +++
 rtl/serialparalelo1.sv | 111 +++++++++++
 tb/tb_serialparalelo1.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serialparalelo1_pkg.sv
// Shared constants, counter widths and FSM encoding for the serialparalelo1 receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serialparalelo1_pkg;

    localparam logic [7:0] COMMA         = 8'hBC;
    localparam int         BC_TARGET_DEF = 4;
    localparam int         BIT_CNT_W     = 3;
    localparam int         BC_CNT_W      = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ALIGNED  = 2'd1,
        ACTIVE   = 2'd2
    } sp_state_t;

endpackage

// File: rtl/serialparalelo1_sp_shift_aligner.sv
// Bit shifter and word-phase counter: builds the candidate word and flags commas and boundaries.
// Latency: w/comma_hit/boundary are combinational on the current bit; counter updates each edge.
// Backpressure: none, one bit accepted every clk_32f edge.
module sp_shift_aligner
    import serialparalelo1_pkg::*;
(
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       locked,
    input  logic       align,
    output logic [7:0] w,
    output logic       boundary,
    output logic       comma_hit
);

    // Only the seven most recent bits are kept; the oldest bit of an 8-bit
    // shifter would never reach any candidate word.
    logic [6:0]           sr;
    logic [BIT_CNT_W-1:0] bit_cnt;

    assign w         = {sr, data_in};
    assign comma_hit = (w == COMMA);
    assign boundary  = locked && (bit_cnt == BIT_CNT_W'(7));

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr <= w[6:0];
            if (align)
                bit_cnt <= '0;
            else if (locked)
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/serialparalelo1.sv
// Serial-to-parallel receiver: comma alignment, lock-in after BC_TARGET commas, byte delivery.
// Latency: outputs update on the edge sampling a word's 8th bit; held until the next boundary.
// Backpressure: none; optional SP_REALIGN_EN lets off-boundary commas force realignment.
module serialparalelo1
    import serialparalelo1_pkg::*;
#(
    parameter int BC_TARGET = BC_TARGET_DEF
)(
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       word_stb
);

    localparam logic [BC_CNT_W-1:0] BC_TGT = BC_CNT_W'(BC_TARGET);

    sp_state_t            state, state_nxt;
    logic [BC_CNT_W-1:0]  bc_cnt, bc_cnt_nxt, bc_cnt_inc;
    logic [7:0]           data_nxt;
    logic                 valid_nxt;
    logic [7:0]           w;
    logic                 boundary, comma_hit, locked, align, realign;

    sp_shift_aligner u_aligner (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .locked    (locked),
        .align     (align),
        .w         (w),
        .boundary  (boundary),
        .comma_hit (comma_hit)
    );

    assign locked     = (state != UNLOCKED);
    assign bc_cnt_inc = bc_cnt + BC_CNT_W'(1);

`ifdef SP_REALIGN_EN
    // A boundary comma is handled by the boundary rules, never as a realignment.
    assign realign = locked && !boundary && comma_hit;
`else
    assign realign = 1'b0;
`endif

    assign align = ((state == UNLOCKED) && comma_hit) || realign;

    always_comb begin
        state_nxt  = state;
        bc_cnt_nxt = bc_cnt;
        data_nxt   = data_out;
        valid_nxt  = valid_out;
        case (state)
            UNLOCKED: begin
                if (comma_hit) begin
                    bc_cnt_nxt = BC_CNT_W'(1);
                    state_nxt  = (BC_TGT == BC_CNT_W'(1)) ? ACTIVE : ALIGNED;
                end
            end
            ALIGNED: begin
                if (boundary) begin
                    if (comma_hit) begin
                        bc_cnt_nxt = bc_cnt_inc;
                        if (bc_cnt_inc >= BC_TGT)
                            state_nxt = ACTIVE;
                    end else begin
                        bc_cnt_nxt = '0;
                        state_nxt  = UNLOCKED;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (comma_hit) begin
                        valid_nxt = 1'b0;
                    end else begin
                        data_nxt  = w;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
        if (realign) begin
            bc_cnt_nxt = BC_CNT_W'(1);
            valid_nxt  = 1'b0;
            state_nxt  = ALIGNED;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state     <= UNLOCKED;
            bc_cnt    <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            word_stb  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bc_cnt    <= bc_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            word_stb  <= boundary;
        end
    end

    assign active = (state == ACTIVE);

endmodule

// File: tb/tb_serialparalelo1.sv
// Bench for serialparalelo1: random and directed bit streams checked against a word-level model.
// Latency: outputs compared 1 time unit after every clk_32f rising edge.
// Backpressure: n/a.
module tb_serialparalelo1;

    localparam int         TGT  = 4;
    localparam logic [7:0] BC   = 8'hBC;
    localparam int         HUNT = 0;
    localparam int         CNT  = 1;
    localparam int         LIVE = 2;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out, active, word_stb;

    int n_checks = 0;
    int n_errors = 0;

    bit hist[$];
    int m_mode, m_since, m_commas, m_data;
    bit m_valid, m_stb;

    serialparalelo1 #(.BC_TARGET(TGT)) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .word_stb  (word_stb)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
        m_mode   = HUNT;
        m_since  = 0;
        m_commas = 0;
        m_data   = 0;
        m_valid  = 1'b0;
        m_stb    = 1'b0;
    endtask

    // Word view: the last eight received bits, oldest bit as MSB.
    task automatic model_step(input bit b);
        int word;
        hist.push_back(b);
        void'(hist.pop_front());
        word = 0;
        for (int i = 0; i < 8; i++) word = word * 2 + int'(hist[i]);
        m_stb = 1'b0;
        if (m_mode == HUNT) begin
            if (word == int'(BC)) begin
                m_commas = 1;
                m_since  = 0;
                m_mode   = (TGT == 1) ? LIVE : CNT;
            end
        end else begin
            m_since++;
            if (m_since % 8 == 0) begin
                m_stb = 1'b1;
                if (m_mode == CNT) begin
                    if (word == int'(BC)) begin
                        m_commas++;
                        if (m_commas >= TGT) m_mode = LIVE;
                    end else begin
                        m_commas = 0;
                        m_mode   = HUNT;
                    end
                end else if (word == int'(BC)) begin
                    m_valid = 1'b0;
                end else begin
                    m_data  = word;
                    m_valid = 1'b1;
                end
            end
`ifdef SP_REALIGN_EN
            else if (word == int'(BC)) begin
                m_since  = 0;
                m_commas = 1;
                m_valid  = 1'b0;
                m_mode   = CNT;
            end
`endif
        end
    endtask

    task automatic compare_all();
        chk("data_out",  32'(data_out),  32'(m_data));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("active",    32'(active),    32'(m_mode == LIVE));
        chk("word_stb",  32'(word_stb),  32'(m_stb));
    endtask

    task automatic send_bit(input bit b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_step(b);
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk_32f);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] dir_words [3];
        dir_words[0] = 8'hFF;
        dir_words[1] = 8'hDD;
        dir_words[2] = 8'hEE;

        // Reset held three cycles with a toggling input.
        reset   = 1'b0;
        data_in = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            data_in = ~data_in;
            @(posedge clk_32f);
            #1;
            chk("rst_data_out", 32'(data_out), 32'h0);
            chk("rst_valid",    32'(valid_out), 32'h0);
            chk("rst_active",   32'(active), 32'h0);
            chk("rst_word_stb", 32'(word_stb), 32'h0);
        end
        reset = 1'b1;

        // Random preamble, commas, random traffic.
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) send_byte(BC);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));

        // Deterministic lock-in from a clean reset.
        pulse_reset();
        send_byte(BC);
        send_byte(BC);
        chk("stb_after_2nd_comma", 32'(word_stb), 32'h1);
        send_byte(BC);
        for (int i = 7; i >= 1; i--) send_bit(BC[i]);
        chk("active_before_last_bit", 32'(active), 32'h0);
        send_bit(BC[0]);
        chk("active_on_4th_comma", 32'(active), 32'h1);

        for (int k = 0; k < 3; k++) begin
            send_byte(dir_words[k]);
            chk("dir_data", 32'(data_out), 32'(dir_words[k]));
            chk("dir_valid", 32'(valid_out), 32'h1);
        end
        send_byte(8'h77);
        chk("data_77", 32'(data_out), 32'h77);
        chk("valid_77", 32'(valid_out), 32'h1);
        send_byte(BC);
        chk("comma_hold_data", 32'(data_out), 32'h77);
        chk("comma_valid_low", 32'(valid_out), 32'h0);

        // Commas shifted by three bits.
        send_byte(8'h55);
        chk("data_55", 32'(data_out), 32'h55);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        send_byte(BC);
`ifdef SP_REALIGN_EN
        chk("realign_drop", 32'(active), 32'h0);
`else
        chk("no_realign_sticky", 32'(active), 32'h1);
`endif
        for (int i = 0; i < 3; i++) send_byte(BC);
        chk("relock_active", 32'(active), 32'h1);
`ifdef SP_REALIGN_EN
        send_byte(8'h42);
        chk("realign_data", 32'(data_out), 32'h42);
        chk("realign_valid", 32'(valid_out), 32'h1);
`endif

        // Reset asserted mid-word while active.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_data", 32'(data_out), 32'h0);
        chk("midrst_valid", 32'(valid_out), 32'h0);
        chk("midrst_active", 32'(active), 32'h0);
        for (int i = 0; i < 2; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            compare_all();
        end
        reset = 1'b1;

        // Broken comma run must not lock; a full run afterwards must.
        for (int i = 0; i < 3; i++) send_byte(BC);
        send_byte(8'h30);
        chk("broken_run_inactive", 32'(active), 32'h0);
        for (int i = 0; i < 3; i++) send_byte(BC);
        chk("three_commas_inactive", 32'(active), 32'h0);
        send_byte(BC);
        chk("relock_after_reset", 32'(active), 32'h1);
        send_byte(8'h5A);
        chk("first_data_after_reset", 32'(data_out), 32'h5A);
        chk("first_valid_after_reset", 32'(valid_out), 32'h1);

        // Random traffic mixed with idle commas.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) send_byte(BC);
            else send_byte(8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
